// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV64M multi-cycle multiply/divide sequencer (shift-add mul, restoring div).
// Optional MULDIV_FAST_MUL_EN: single-cycle array multiply in the MUL state.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [63:0] r_acc, r_mcand, r_mplier;
    logic [63:0] r_rem, r_quo, r_div, r_result;
    logic [6:0]  r_cnt;
    logic        r_is_w, r_is_rem, r_neg_q, r_neg_r;

    function automatic logic [63:0] sext_w(input logic w, input logic [63:0] v);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    logic        w_is_div, w_is_w, w_signed, w_sx;
    logic [63:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_special_val;
    logic        w_neg_a, w_neg_b, w_b_zero, w_ovf, w_special;
    logic [6:0]  w_n;

    assign w_is_div = op[2];
    assign w_is_w   = op[3];
    assign w_signed = w_is_div & ~op[0];
    assign w_sx     = ~op[2] | ~op[0];
    assign w_a_ext  = !w_is_w ? a : (w_sx ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]});
    assign w_b_ext  = !w_is_w ? b : (w_sx ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]});
    assign w_neg_a  = w_signed & w_a_ext[63];
    assign w_neg_b  = w_signed & w_b_ext[63];
    assign w_a_mag  = w_neg_a ? -w_a_ext : w_a_ext;
    assign w_b_mag  = w_neg_b ? -w_b_ext : w_b_ext;

    assign w_b_zero = (w_b_ext == 64'd0);
    assign w_ovf    = w_signed & (&w_b_ext) &
                      (w_a_ext == (w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign w_special     = w_is_div & (w_b_zero | w_ovf);
    assign w_special_val = w_b_zero ? (op[1] ? w_a_ext : {64{1'b1}})
                                    : (op[1] ? 64'd0 : w_a_ext);

`ifdef MULDIV_FAST_MUL_EN
    assign w_n = (!w_is_div) ? 7'd1 : (w_is_w ? 7'd32 : 7'd64);
`else
    assign w_n = w_is_w ? 7'd32 : 7'd64;
`endif

    // Restoring step: 65-bit trial subtraction so a full 64-bit divisor never overflows.
    logic [64:0] w_rem_sh, w_diff;
    logic        w_ge;
    logic [63:0] w_rem_nx, w_quo_nx, w_acc_nx, w_q_fix, w_r_fix;
    logic        w_last;

    assign w_rem_sh = {r_rem, r_quo[63]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_ge     = ~w_diff[64];
    assign w_rem_nx = w_ge ? w_diff[63:0] : w_rem_sh[63:0];
    assign w_quo_nx = {r_quo[62:0], w_ge};
    assign w_q_fix  = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fix  = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_last   = (r_cnt == 7'd1);

`ifdef MULDIV_FAST_MUL_EN
    assign w_acc_nx = r_acc + r_mcand * r_mplier;
`else
    assign w_acc_nx = r_mplier[0] ? r_acc + r_mcand : r_acc;
`endif

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = w_special ? S_DONE : (w_is_div ? S_DIV : S_MUL);
            S_MUL:  if (w_last) w_next = S_DONE;
            S_DIV:  if (w_last) w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_is_w   <= 1'b0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_is_w   <= w_is_w;
                    r_is_rem <= op[1];
                    r_neg_q  <= w_neg_a ^ w_neg_b;
                    r_neg_r  <= w_neg_a;
                    r_cnt    <= w_n;
                    r_acc    <= '0;
                    r_mcand  <= w_a_ext;
                    r_mplier <= w_b_ext;
                    r_rem    <= '0;
                    // W dividends sit in the top half so the MSB shift-out is always bit 63.
                    r_quo    <= w_is_w ? {w_a_mag[31:0], 32'b0} : w_a_mag;
                    r_div    <= w_b_mag;
                    if (w_special) r_result <= sext_w(w_is_w, w_special_val);
                end
                S_MUL: begin
                    r_acc    <= w_acc_nx;
                    r_mcand  <= {r_mcand[62:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[63:1]};
                    r_cnt    <= r_cnt - 7'd1;
                    if (w_last) r_result <= sext_w(r_is_w, w_acc_nx);
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - 7'd1;
                    if (w_last) r_result <= sext_w(r_is_w, r_is_rem ? w_r_fix : w_q_fix);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed scoreboard bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;
    logic [63:0] sb_q[$];

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MULW_LAT = 1;
`else
    localparam int MUL_LAT  = 64;
    localparam int MULW_LAT = 32;
`endif

    localparam logic [3:0] OP_MUL = 4'b0000, OP_DIV = 4'b0100, OP_DIVU = 4'b0101,
                           OP_REM = 4'b0110, OP_REMU = 4'b0111, OP_MULW = 4'b1000,
                           OP_DIVW = 4'b1100, OP_REMW = 4'b1110, OP_REMUW = 4'b1111;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] x,
                          input logic [63:0] y, input logic [63:0] exp, input int lat,
                          input int hold);
        int n;
        logic [63:0] e;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        sb_q.push_back(exp);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        e = sb_q.pop_front();
        chk({tag, "_result"}, result, e);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; op = OP_MUL; a = 64'd3; b = 64'd3;
            tick();
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_result"}, result, e);
            chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        logic [63:0] mx, my;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();

        run_op("div_neg7_2", OP_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0);
        run_op("rem_neg7_2", OP_REM, -64'sd7, 64'd2, {64{1'b1}}, 64, 10);
        run_op("divu_by0", OP_DIVU, 64'd5, 64'd0, {64{1'b1}}, 0, 0);
        run_op("remu_by0", OP_REMU, 64'd5, 64'd0, 64'd5, 0, 0);
        run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000, 0, 0);
        run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'd0, 0, 0);
        run_op("divw_ovf", OP_DIVW, 64'h0000_0000_8000_0000, {64{1'b1}}, 64'hFFFF_FFFF_8000_0000, 0, 0);
        run_op("mulw_sat", OP_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT, 0);
        run_op("remuw_hi", OP_REMUW, 64'h0000_0001_0000_0007, 64'd3, 64'd1, 32, 0);

        mx = 64'h1234_5678_9ABC_DEF0;
        my = 64'hFEDC_BA98_7654_3211;
        run_op("mul_model", OP_MUL, mx, my, mx * my, MUL_LAT, 0);
        run_op("divu_model", OP_DIVU, my, 64'd12345, my / 64'd12345, 64, 0);
        run_op("divw_neg", OP_DIVW, -64'sd100, 64'd7, -64'sd14, 32, 0);
        run_op("remw_neg", OP_REMW, -64'sd100, 64'd7, -64'sd2, 32, 0);

        // Flush at T+20 of a divide: the operation must vanish without a result.
        op = OP_DIV; a = 64'd1000; b = 64'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (19) tick();
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", 64'(in_ready), 64'd1);
        chk("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);

        // Flush together with in_valid in IDLE: nothing accepted.
        op = OP_MUL; a = 64'd9; b = 64'd9; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_idle", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (out_valid || busy) seen++;
        end
        chk("flush_acc_nothing", 64'(seen), 64'd0);

        // Reset mid-operation behaves like flush.
        op = OP_DIVU; a = 64'd77; b = 64'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_result", result, 64'd0);

        run_op("after_rst", OP_DIVU, 64'd77, 64'd5, 64'd15, 64, 0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV64M multiply/divide datapath in the execute stage. It accepts one M-extension operation at a time, using the 4-bit `mulOp` encoding produced by the decoder. It runs a shift-add multiplier or a restoring divider over the required number of cycles and returns a 64-bit result through a valid/ready handshake. Its `busy` and `in_ready` outputs drive the pipeline stall logic, and `flush` abandons an in-flight operation on redirect.

## Interface
- No parameters; widths are fixed by the RV64 datapath.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low; sampled on `clk` rising edge.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: block can accept; high only in IDLE.
- `op` input 4: mulOp encoding.
  - `op[2]`=0: multiply.
  - `op[2]`=1: divide/remainder; `op[0]`=1 unsigned, `op[1]`=1 remainder.
  - `op[3]`=1: W variant.
- `a` input 64: rs1 operand.
- `b` input 64: rs2 operand.
- `flush` input 1: abort current operation.
- `out_valid` output 1: `result` valid; high only in DONE.
- `out_ready` input 1: consumer takes result.
- `result` output 64: final value.
- `busy` output 1: state != IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid`, latch op/a/b. Go to DONE for special cases, else to MUL or DIV.
  - MUL: shift-add multiplier, 1 bit per cycle.
  - DIV: restoring divider, 1 quotient bit per cycle.
  - DONE: `out_valid`=1, `result` held stable. Go to IDLE on `out_ready`.
- Iteration count N: 64 for non-W, 32 for W.
- Operand preparation:
  - W variants use `a[31:0]`/`b[31:0]`; signed W ops sign-extend them from bit 31.
  - Signed divide/remainder iterates on magnitudes.
- Sign fix-up, applied on entry to DONE:
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
- Multiply result:
  - mul: low 64 bits of the product; signedness is irrelevant.
  - mulw: product bits [31:0], sign-extended to 64.
- W results: every W result is sign-extended from bit 31, including divuw/remuw.
- Special cases, detected in IDLE; go directly to DONE with no iteration:
  - Divisor zero: quotient = all ones (64'hFFFF_FFFF_FFFF_FFFF, W: sign-extended 32'hFFFF_FFFF); remainder = dividend (W: sign-extended low 32).
  - Signed overflow: dividend = most-negative and divisor = -1. Quotient = dividend; remainder = 0.
- Flush:
  - `flush`=1 forces IDLE at the next edge from any state; any pending result is discarded.
  - Flush beats acceptance in the same cycle: nothing is latched.
- Reset: every output register clears.
  - State IDLE, `out_valid`=0, `result`=0, `busy`=0, `in_ready`=1 on the first cycle after reset deasserts.
  - Reset mid-operation abandons the operation identically to flush.
- Handshake:
  - No new acceptance while in DONE.
  - The minimum gap between accepts is one idle cycle after the result handshake.

## Timing
- Accept edge T (`in_valid` && `in_ready` sampled high).
- MUL/DIV occupy cycles T+1 .. T+N.
- `out_valid` rises at T+N+1.
- Special cases: `out_valid` at T+1.
- `result` is registered; no combinational path from `a`/`b`/`op` to `result`.
- `out_valid` stays high, with `result` constant, until the edge where `out_ready`=1; IDLE is entered the following cycle.
- `busy` = !`in_ready`, registered from state.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - The MUL state lasts exactly one cycle using a single-cycle 64x64 array product; N=1 for mul and mulw.
  - Division is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: iterative shift-add multiply, N=64 (mul) or 32 (mulw).

## Test plan
- Reset then divide: `reset`=0 for 2 cycles → `in_ready`=1, `out_valid`=0, `result`=0. Then div a=-7, b=2 → `result`=-3 (64'hFFFF_FFFF_FFFF_FFFD) at T+65; rem of the same operands → -1.
- divu by zero: a=5, b=0 → `result`=64'hFFFF_FFFF_FFFF_FFFF at T+1. remu of the same operands → 5.
- Overflow: div a=64'h8000_0000_0000_0000, b=-1 → `result`=a, rem → 0, both at T+1. divw a=32'h8000_0000, b=-1 → 64'hFFFF_FFFF_8000_0000.
- mulw a=32'h7FFF_FFFF, b=2 → 64'hFFFF_FFFF_FFFF_FFFE. Result at T+33, or T+2 with `MULDIV_FAST_MUL_EN`.
- Backpressure and flush:
  - Hold `out_ready`=0 for 10 cycles in DONE → `result` stable, `in_valid` ignored.
  - Assert `flush` at T+20 of a div → IDLE at T+21, no `out_valid` ever for that operation.
  - `flush` and `in_valid` together in IDLE → nothing accepted.
- remuw a=64'h1_0000_0007, b=3 → uses low 32 bits → `result`=1.
